// File: rtl/hazard_unit_param_if.sv
// Signal bundle between the pipeline registers and the hazard unit.
// The pipeline drives addresses/controls; the hazard unit returns stalls, flushes and forward selects.
interface hazard_unit_param_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
);
  logic [REG_AW-1:0]         Dreg1_addr;
  logic [REG_AW-1:0]         Dreg2_addr;
  logic [NUM_SRC*REG_AW-1:0] Ereg_addr;
  logic [REG_AW-1:0]         Ewrite_reg_addr;
  logic                      Eload_sig;
  logic [REG_AW-1:0]         Mwrite_reg_addr;
  logic                      Mwrite_reg_sig;
  logic [REG_AW-1:0]         Wwrite_reg_addr;
  logic                      Wwrite_reg_sig;
  logic                      branch_sig;
  logic [4:0]                alucode;
  logic [NUM_SRC*2-1:0]      forwardE;
  logic                      stallF;
  logic                      stallD;
  logic                      stallE;
  logic                      flushD;
  logic                      flushE;
  logic                      flushM;
  logic                      md_busy;
  logic                      md_done;

  modport master (
    output Dreg1_addr, Dreg2_addr, Ereg_addr, Ewrite_reg_addr, Eload_sig,
           Mwrite_reg_addr, Mwrite_reg_sig, Wwrite_reg_addr, Wwrite_reg_sig,
           branch_sig, alucode,
    input  forwardE, stallF, stallD, stallE, flushD, flushE, flushM, md_busy, md_done
  );

  modport slave (
    input  Dreg1_addr, Dreg2_addr, Ereg_addr, Ewrite_reg_addr, Eload_sig,
           Mwrite_reg_addr, Mwrite_reg_sig, Wwrite_reg_addr, Wwrite_reg_sig,
           branch_sig, alucode,
    output forwardE, stallF, stallD, stallE, flushD, flushE, flushM, md_busy, md_done
  );
endinterface

// File: rtl/hazard_unit_param.sv
// Hazard unit for the 5-stage RV32IM pipeline: EX forwarding, load-use stall, branch flush,
// and an IDLE/BUSY sequencer that holds multi-cycle M-extension ops in E.
module hazard_unit_param #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 6,
  parameter int unsigned REM_LAT = 6,
  parameter int unsigned CNT_W   = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_unit_param_if.slave hz
);

  localparam logic [1:0] NORMAL    = 2'd0;
  localparam logic [1:0] WRITEMEM  = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;

  localparam logic [4:0] ALU_MUL    = 5'd19;
  localparam logic [4:0] ALU_MULH   = 5'd20;
  localparam logic [4:0] ALU_MULHSU = 5'd21;
  localparam logic [4:0] ALU_MULHU  = 5'd22;
  localparam logic [4:0] ALU_DIV    = 5'd23;
  localparam logic [4:0] ALU_DIVU   = 5'd24;
  localparam logic [4:0] ALU_REM    = 5'd25;
  localparam logic [4:0] ALU_REMU   = 5'd26;

  localparam int unsigned MaxLat0 = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned MaxLat  = (MaxLat0 > REM_LAT) ? MaxLat0 : REM_LAT;

  if (CNT_W == 0 || (MaxLat >> CNT_W) != 0) begin : g_cnt_w_check
    $error("hazard_unit_param: CNT_W is too narrow for the configured latencies");
  end

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              issued_q;
  logic              done_q;

  logic              md_op;
  logic [CNT_W-1:0]  op_lat;
  logic              start_md;
  logic              busy;
  logic              luse;
  logic [REG_AW-1:0] src;

  always_comb begin
    md_op  = 1'b1;
    op_lat = '0;
    case (hz.alucode)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: op_lat = CNT_W'(MUL_LAT);
      ALU_DIV, ALU_DIVU:                        op_lat = CNT_W'(DIV_LAT);
      ALU_REM, ALU_REMU:                        op_lat = CNT_W'(REM_LAT);
      default:                                  md_op  = 1'b0;
    endcase
  end

  // issued_q blocks the still-present op from restarting on the cycle it finally leaves E.
  assign busy     = (state_q == StBusy);
  assign start_md = !busy && md_op && !hz.branch_sig && !issued_q && (op_lat != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_md) begin
            state_q  <= StBusy;
            cnt_q    <= op_lat;
            issued_q <= 1'b1;
            done_q   <= (op_lat == CNT_W'(1));
          end else begin
            issued_q <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        StBusy: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(2));
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign luse = hz.Eload_sig && (hz.Ewrite_reg_addr != '0) &&
                ((hz.Ewrite_reg_addr == hz.Dreg1_addr) || (hz.Ewrite_reg_addr == hz.Dreg2_addr));

  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushM = 1'b0;
    if (reset) begin
      hz.stallF = 1'b0;
    end else if (busy) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (hz.branch_sig) begin
      // D holds a wrong-path instruction, so a coincident load-use needs no stall.
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
    end else if (luse) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

  assign hz.md_busy = busy;
  assign hz.md_done = done_q;

  always_comb begin
    hz.forwardE = '0;
    src         = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = hz.Ereg_addr[i*REG_AW +: REG_AW];
      if (hz.Mwrite_reg_sig && src != '0 && src == hz.Mwrite_reg_addr) begin
        hz.forwardE[i*2 +: 2] = WRITEMEM;
      end else if (hz.Wwrite_reg_sig && src != '0 && src == hz.Wwrite_reg_addr) begin
        hz.forwardE[i*2 +: 2] = WRITEBACK;
      end else begin
        hz.forwardE[i*2 +: 2] = NORMAL;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Randomised and directed bench for hazard_unit_param against a cycle-indexed reference model.
module tb_hazard_unit_param;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 6;
  localparam int unsigned REM_LAT = 6;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] NORMAL    = 2'd0;
  localparam logic [1:0] WRITEMEM  = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;

  localparam logic [4:0] ALU_MUL  = 5'd19;
  localparam logic [4:0] ALU_DIV  = 5'd23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_param_if #(.REG_AW(REG_AW), .NUM_SRC(2)) hz ();
  hazard_unit_param_if #(.REG_AW(REG_AW), .NUM_SRC(3)) hz3 ();

  hazard_unit_param #(
    .REG_AW(REG_AW), .NUM_SRC(2), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .REM_LAT(REM_LAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(rst), .hz(hz.slave)
  );

  hazard_unit_param #(
    .REG_AW(REG_AW), .NUM_SRC(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .REM_LAT(REM_LAT),
    .CNT_W(CNT_W)
  ) dut3 (
    .clk(clk), .reset(rst), .hz(hz3.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: an op started in cycle s with latency L is busy in cycles s+1..s+L, done in s+L,
  // and may not restart in s+L+1.
  int cyc       = 0;
  bit md_active = 1'b0;
  int md_start  = 0;
  int md_lat    = 0;

  logic [7:0] obs_ctl;
  int busy_cnt, done_cnt;

  logic [4:0] md_codes [8] = '{5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op);
    if (op >= 5'd19 && op <= 5'd22) return int'(MUL_LAT);
    if (op == 5'd23 || op == 5'd24) return int'(DIV_LAT);
    if (op == 5'd25 || op == 5'd26) return int'(REM_LAT);
    return -1;
  endfunction

  function automatic logic [1:0] fwd_one(input logic [4:0] a, input logic [4:0] mrd,
                                         input logic msig, input logic [4:0] wrd,
                                         input logic wsig);
    if (a == 0) return NORMAL;
    if (msig && a == mrd) return WRITEMEM;
    if (wsig && a == wrd) return WRITEBACK;
    return NORMAL;
  endfunction

  function automatic logic [5:0] fwd_vec(input logic [14:0] ereg, input int n,
                                         input logic [4:0] mrd, input logic msig,
                                         input logic [4:0] wrd, input logic wsig);
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*2 +: 2] = fwd_one(ereg[i*5 +: 5], mrd, msig, wrd, wsig);
    return v;
  endfunction

  task automatic step(input string tag);
    bit busy, done, hold, luse;
    logic [7:0] exp_ctl;
    logic [5:0] exp_f2, exp_f3;
    @(negedge clk);
    #1;
    busy = !rst && md_active && cyc > md_start && cyc <= md_start + md_lat;
    done = busy && cyc == md_start + md_lat;
    hold = md_active && cyc == md_start + md_lat + 1;
    luse = hz.Eload_sig && hz.Ewrite_reg_addr != 0 &&
           (hz.Ewrite_reg_addr == hz.Dreg1_addr || hz.Ewrite_reg_addr == hz.Dreg2_addr);
    // {stallF, stallD, stallE, flushD, flushE, flushM, md_busy, md_done}
    if (rst)                exp_ctl = 8'b000000_00;
    else if (busy)          exp_ctl = {6'b111001, 1'b1, done};
    else if (hz.branch_sig) exp_ctl = 8'b000110_00;
    else if (luse)          exp_ctl = 8'b110010_00;
    else                    exp_ctl = 8'b000000_00;
    obs_ctl = {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM,
               hz.md_busy, hz.md_done};
    exp_f2 = fwd_vec({5'd0, hz.Ereg_addr}, 2, hz.Mwrite_reg_addr, hz.Mwrite_reg_sig,
                     hz.Wwrite_reg_addr, hz.Wwrite_reg_sig);
    exp_f3 = fwd_vec(hz3.Ereg_addr, 3, hz3.Mwrite_reg_addr, hz3.Mwrite_reg_sig,
                     hz3.Wwrite_reg_addr, hz3.Wwrite_reg_sig);
    check({tag, "/ctl"}, 32'(obs_ctl), 32'(exp_ctl));
    check({tag, "/fwd"}, 32'(hz.forwardE), 32'(exp_f2));
    check({tag, "/fwd3"}, 32'(hz3.forwardE), 32'(exp_f3));
    if (rst) begin
      md_active = 1'b0;
    end else if (!busy && !hold && !hz.branch_sig && lat_of(hz.alucode) > 0) begin
      md_active = 1'b1;
      md_start  = cyc;
      md_lat    = lat_of(hz.alucode);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    hz.Dreg1_addr = '0;       hz.Dreg2_addr = '0;      hz.Ereg_addr = '0;
    hz.Ewrite_reg_addr = '0;  hz.Eload_sig = 1'b0;     hz.Mwrite_reg_addr = '0;
    hz.Mwrite_reg_sig = 1'b0; hz.Wwrite_reg_addr = '0; hz.Wwrite_reg_sig = 1'b0;
    hz.branch_sig = 1'b0;     hz.alucode = '0;
    hz3.Dreg1_addr = '0;      hz3.Dreg2_addr = '0;     hz3.Ereg_addr = '0;
    hz3.Ewrite_reg_addr = '0; hz3.Eload_sig = 1'b0;    hz3.Mwrite_reg_addr = '0;
    hz3.Mwrite_reg_sig = 1'b0; hz3.Wwrite_reg_addr = '0; hz3.Wwrite_reg_sig = 1'b0;
    hz3.branch_sig = 1'b0;    hz3.alucode = '0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // Forwarding
    hz.Ereg_addr = {5'd3, 5'd3};
    hz.Mwrite_reg_addr = 5'd3; hz.Mwrite_reg_sig = 1'b1;
    hz.Wwrite_reg_addr = 5'd3; hz.Wwrite_reg_sig = 1'b1;
    step("fwd_mm");
    check("fwd_mm_const", 32'(hz.forwardE), 32'({WRITEMEM, WRITEMEM}));
    hz.Mwrite_reg_sig = 1'b0;
    step("fwd_ww");
    check("fwd_ww_const", 32'(hz.forwardE), 32'({WRITEBACK, WRITEBACK}));
    hz.Ereg_addr = '0; hz.Mwrite_reg_addr = '0; hz.Wwrite_reg_addr = '0;
    hz.Mwrite_reg_sig = 1'b1;
    step("fwd_x0");
    check("fwd_x0_const", 32'(hz.forwardE), 32'({NORMAL, NORMAL}));

    // Load-use
    set_idle();
    hz.Eload_sig = 1'b1; hz.Ewrite_reg_addr = 5'd5; hz.Dreg2_addr = 5'd5;
    step("luse");
    check("luse_const", 32'(obs_ctl), 32'(8'b110010_00));
    hz.Eload_sig = 1'b0;
    step("luse_off");
    check("luse_off_const", 32'(obs_ctl), 32'(8'b0));

    // DIV: trigger, 6 busy cycles, one blocked cycle with the op still present
    set_idle();
    hz.alucode = ALU_DIV;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step("div");
      busy_cnt += int'(obs_ctl[1]);
      done_cnt += int'(obs_ctl[0]);
      if (i == 6) check("div_done_on_6th", 32'(obs_ctl[0]), 32'd1);
    end
    check("div_busy_cycles", 32'(busy_cnt), 32'd6);
    check("div_done_count", 32'(done_cnt), 32'd1);
    check("div_no_reenter", 32'(obs_ctl[1]), 32'd0);
    hz.alucode = '0;
    step("div_after");

    // MUL during a taken branch, then branch + load-use
    hz.alucode = ALU_MUL; hz.branch_sig = 1'b1;
    step("mul_branch");
    check("mul_branch_const", 32'(obs_ctl), 32'(8'b000110_00));
    hz.alucode = '0; hz.branch_sig = 1'b0;
    step("mul_branch_after");
    hz.branch_sig = 1'b1; hz.Eload_sig = 1'b1; hz.Ewrite_reg_addr = 5'd5; hz.Dreg1_addr = 5'd5;
    step("br_luse");
    check("br_luse_stallF", 32'(obs_ctl[7]), 32'd0);
    set_idle();

    // Async reset during DIV, then MUL
    hz.alucode = ALU_DIV;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step("div_pre_rst");
      done_cnt += int'(obs_ctl[0]);
    end
    rst = 1'b1;
    #1;
    check("rst_async_stallE", 32'(hz.stallE), 32'd0);
    check("rst_async_busy", 32'(hz.md_busy), 32'd0);
    step("div_rst");
    done_cnt += int'(obs_ctl[0]);
    rst = 1'b0;
    hz.alucode = '0;
    step("post_rst");
    done_cnt += int'(obs_ctl[0]);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    hz.alucode = ALU_MUL;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step("mul");
      busy_cnt += int'(obs_ctl[1]);
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd2);
    set_idle();

    // Three-operand build
    hz3.Ereg_addr = {5'd7, 5'd1, 5'd2};
    hz3.Wwrite_reg_addr = 5'd7; hz3.Wwrite_reg_sig = 1'b1;
    hz3.Mwrite_reg_addr = 5'd9; hz3.Mwrite_reg_sig = 1'b1;
    step("src3");
    check("src3_const", 32'(hz3.forwardE), 32'({WRITEBACK, NORMAL, NORMAL}));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      hz.Dreg1_addr      = 5'($urandom_range(0, 7));
      hz.Dreg2_addr      = 5'($urandom_range(0, 7));
      hz.Ereg_addr       = 10'($urandom_range(0, 1023)) & 10'b00111_00111;
      hz.Ewrite_reg_addr = 5'($urandom_range(0, 7));
      hz.Eload_sig       = ($urandom_range(0, 2) == 0);
      hz.Mwrite_reg_addr = 5'($urandom_range(0, 7));
      hz.Mwrite_reg_sig  = 1'($urandom_range(0, 1));
      hz.Wwrite_reg_addr = 5'($urandom_range(0, 7));
      hz.Wwrite_reg_sig  = 1'($urandom_range(0, 1));
      hz.branch_sig      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) hz.alucode = md_codes[$urandom_range(0, 7)];
      else                           hz.alucode = 5'($urandom_range(0, 31));
      hz3.Ereg_addr       = 15'($urandom) & 15'b00111_00111_00111;
      hz3.Mwrite_reg_addr = 5'($urandom_range(0, 7));
      hz3.Mwrite_reg_sig  = 1'($urandom_range(0, 1));
      hz3.Wwrite_reg_addr = 5'($urandom_range(0, 7));
      hz3.Wwrite_reg_sig  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised successor hazard unit for the 5-stage RV32IM pipeline.
- Generates EX-stage forwarding selects for NUM_SRC operands, load-use stall detection, and branch flush.
- Handles multi-cycle M-extension ops with an explicit IDLE/BUSY FSM: the op is held in E while bubbles are inserted into M. Wrong-path ops are not flushed repeatedly.
- Sits between the decode/execute pipeline registers and the writeback mux, like the existing hazard logic.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of EX source operands checked for forwarding
MUL_LAT, 2, extra stall cycles for MUL/MULH/MULHSU/MULHU
DIV_LAT, 6, extra stall cycles for DIV/DIVU
REM_LAT, 6, extra stall cycles for REM/REMU
CNT_W, 4, busy counter width; must hold max(*_LAT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
Dreg1_addr  in  REG_AW  rs1 of instruction in D
Dreg2_addr  in  REG_AW  rs2 of instruction in D
Ereg_addr  in  NUM_SRC*REG_AW  packed EX source addresses, operand i at [i*REG_AW +: REG_AW]
Ewrite_reg_addr  in  REG_AW  rd of instruction in E
Eload_sig  in  1  instruction in E is a load
Mwrite_reg_addr  in  REG_AW  rd in M
Mwrite_reg_sig  in  1  M writes rd
Wwrite_reg_addr  in  REG_AW  rd in W
Wwrite_reg_sig  in  1  W writes rd
branch_sig  in  1  taken branch/jump resolved in E
alucode  in  5  ALU op of instruction in E (`MUL..`REMU from 99_define.vh)
forwardE  out  NUM_SRC*2  per-operand select: `NORMAL / `WRITEMEM / `WRITEBACK
stallF  out  1  hold PC
stallD  out  1  hold IF/ID register
stallE  out  1  hold ID/EX register
flushD  out  1  clear IF/ID register
flushE  out  1  clear ID/EX register
flushM  out  1  insert bubble into EX/MEM register
md_busy  out  1  FSM in BUSY
md_done  out  1  one-cycle pulse on final stall cycle

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0. All stall/flush outputs and md_done are 0 while reset is asserted. forwardE stays combinational. Reset mid-BUSY aborts the op; no md_done pulse.
- Forwarding (combinational, per operand i):
  - M match (Mwrite_reg_sig && addr!=0 && addr==Mwrite_reg_addr) gives `WRITEMEM.
  - Else W match gives `WRITEBACK.
  - Else `NORMAL.
  - M has priority when both match. x0 is never forwarded.
- md_op = alucode in {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU}. LAT(op) is selected from the parameters.
- FSM:
  - IDLE → BUSY when md_op && !branch_sig; load cnt=LAT(op). If LAT(op)==0, stay IDLE with no stall.
  - BUSY: cnt decrements each cycle. md_done=1 when cnt==1. BUSY → IDLE when cnt==1.
  - The E instruction completes on the cycle after md_done, with no re-trigger. An internal issued flag is set on the IDLE→BUSY transition and cleared when stallE drops.
- While BUSY:
  - stallF=stallD=stallE=1, flushM=1, flushE=0.
  - branch_sig and load-use are ignored.
  - forwardE is still driven from live M/W inputs.
- Load-use (IDLE only):
  - luse = Eload_sig && Ewrite_reg_addr!=0 && (Ewrite_reg_addr==Dreg1_addr || ==Dreg2_addr).
  - luse gives stallF=stallD=1 and flushE=1 for exactly one cycle.
- Branch (IDLE only): flushD=flushE=1.
- Priority: BUSY > branch > load-use. On branch+luse in the same cycle, flush only, no stall: the D instruction is wrong-path.
- cnt never wraps. Out-of-range CNT_W is a configuration error, checked by an elaboration-time assertion.

Test Plan:
- Forward both: Ereg_addr={5'd3,5'd3}, M rd=3 sig=1, W rd=3 sig=1 → forwardE={`WRITEMEM,`WRITEMEM}. With M sig=0 → {`WRITEBACK,`WRITEBACK}. With rd=0 → `NORMAL.
- Load-use: Eload_sig=1, Erd=5, Dreg2_addr=5 → stallF/stallD/flushE high exactly 1 cycle, then low when Eload_sig drops.
- DIV with DIV_LAT=6: alucode=`DIV held → md_busy high 6 cycles, stallE/flushM high 6 cycles, md_done on 6th; FSM does not re-enter BUSY on the next cycle.
- MUL during taken branch: alucode=`MUL with branch_sig=1 → no BUSY, flushD=flushE=1. Branch+load-use in the same cycle → flush only, stallF=0.
- Async reset asserted at cycle 3 of DIV → all stall/flush outputs 0 immediately, md_busy=0, no md_done. Next `MUL after release → 2-cycle stall.
- NUM_SRC=3 build: third operand matching W rd=7 → forwardE[5:4]=`WRITEBACK. Other operands are unaffected.
